// File: rtl/alu_share_arbiter_if.sv
// Request, response and ALU-side signals of the two-requester shared ALU arbiter.
// slave is the arbiter's view; master is the requesters' and ALU's side.
interface alu_share_arbiter_if #(
    parameter int OPW  = 3,
    parameter int RESW = 6
);
    logic            req0_valid;
    logic            req0_ready;
    logic [OPW-1:0]  req0_a;
    logic [OPW-1:0]  req0_b;
    logic [1:0]      req0_sel;
    logic            req1_valid;
    logic            req1_ready;
    logic [OPW-1:0]  req1_a;
    logic [OPW-1:0]  req1_b;
    logic [1:0]      req1_sel;

    logic            rsp0_valid;
    logic            rsp0_ready;
    logic [RESW-1:0] rsp0_data;
    logic            rsp0_dz;
    logic            rsp1_valid;
    logic            rsp1_ready;
    logic [RESW-1:0] rsp1_data;
    logic            rsp1_dz;

    logic [OPW-1:0]  alu_a;
    logic [OPW-1:0]  alu_b;
    logic [1:0]      alu_sel;
    logic [RESW-1:0] alu_result;
    logic            busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sel,
        input  req1_valid, req1_a, req1_b, req1_sel,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_data, rsp0_dz,
        output rsp1_valid, rsp1_data, rsp1_dz,
        input  rsp0_ready, rsp1_ready,
        output alu_a, alu_b, alu_sel, busy,
        input  alu_result
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_sel,
        output req1_valid, req1_a, req1_b, req1_sel,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_data, rsp0_dz,
        input  rsp1_valid, rsp1_data, rsp1_dz,
        output rsp0_ready, rsp1_ready,
        input  alu_a, alu_b, alu_sel, busy,
        output alu_result
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters,
// one operation in flight: IDLE (grant) -> EXEC (ALU settles) -> RESP (hold result).
module alu_share_arbiter #(
    parameter int OPW  = 3,
    parameter int RESW = 6
) (
    input  logic                clk,
    input  logic                rst,
    alu_share_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic            ptr_reg;
    logic            ptr_next;
    logic            owner_reg;
    logic [OPW-1:0]  a_reg;
    logic [OPW-1:0]  b_reg;
    logic [1:0]      sel_reg;
    logic [RESW-1:0] res_reg;
    logic            dz_reg;

    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready;
    logic [OPW-1:0]  req_a   [2];
    logic [OPW-1:0]  req_b   [2];
    logic [1:0]      req_sel [2];
    logic [RESW-1:0] rsp_data [2];
    logic [1:0]      rsp_dz;
    logic            grant_id;
    logic            accept;

    assign req_valid  = {bus.req1_valid, bus.req0_valid};
    assign rsp_ready  = {bus.rsp1_ready, bus.rsp0_ready};
    assign req_a[0]   = bus.req0_a;
    assign req_a[1]   = bus.req1_a;
    assign req_b[0]   = bus.req0_b;
    assign req_b[1]   = bus.req1_b;
    assign req_sel[0] = bus.req0_sel;
    assign req_sel[1] = bus.req1_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A lone requester wins outright; the pointer only breaks ties.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        grant_id   = ptr_reg;
        accept     = 1'b0;
        req_ready  = 2'b00;
        rsp_valid  = 2'b00;
        if (req_valid == 2'b01) begin
            grant_id = 1'b0;
        end else if (req_valid == 2'b10) begin
            grant_id = 1'b1;
        end
        case (state_reg)
            IDLE: begin
                if ((|req_valid) && !rst) begin
                    req_ready[grant_id] = 1'b1;
                    accept              = 1'b1;
                    state_next          = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                rsp_valid[owner_reg] = 1'b1;
                if (rsp_ready[owner_reg]) begin
                    ptr_next   = ~owner_reg;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operands are copied on accept so requesters may change theirs afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg   <= 1'b0;
            owner_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sel_reg   <= 2'b00;
            res_reg   <= '0;
            dz_reg    <= 1'b0;
        end else begin
            ptr_reg <= ptr_next;
            if (accept) begin
                owner_reg <= grant_id;
                a_reg     <= req_a[grant_id];
                b_reg     <= req_b[grant_id];
                sel_reg   <= req_sel[grant_id];
            end
            if (state_reg == EXEC) begin
                res_reg <= bus.alu_result;
                dz_reg  <= (sel_reg == 2'b11) && (b_reg == '0);
            end
        end
    end

    // Non-owner response lanes read as zero.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rsp
            assign rsp_data[gi] = rsp_valid[gi] ? res_reg : '0;
            assign rsp_dz[gi]   = rsp_valid[gi] & dz_reg;
        end
    endgenerate

    assign bus.req0_ready = req_ready[0];
    assign bus.req1_ready = req_ready[1];
    assign bus.rsp0_valid = rsp_valid[0];
    assign bus.rsp1_valid = rsp_valid[1];
    assign bus.rsp0_data  = rsp_data[0];
    assign bus.rsp1_data  = rsp_data[1];
    assign bus.rsp0_dz    = rsp_dz[0];
    assign bus.rsp1_dz    = rsp_dz[1];
    assign bus.alu_a      = a_reg;
    assign bus.alu_b      = b_reg;
    assign bus.alu_sel    = sel_reg;
    assign bus.busy       = (state_reg != IDLE);
endmodule
